// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int OVERSAMPLE = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

endpackage
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl
// Description : UART transmit sequencer framing a byte into start/data/
//               parity/stop bits, timed by a 16x oversampling tick.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int                 c_BIT_W     = $clog2(DATA_BITS + 1);
    localparam logic [3:0]         c_TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);
    localparam logic [4:0]         c_STOP_LAST = 5'(OVERSAMPLE * STOP_BITS - 1);

    tx_state_t              r_state,    w_state_nxt;
    logic [3:0]             r_tick_cnt, w_tick_nxt;
    logic [c_BIT_W-1:0]     r_bit_cnt,  w_bit_nxt;
    logic [4:0]             r_stop_cnt, w_stop_nxt;
    logic [DATA_BITS-1:0]   r_shreg,    w_shreg_nxt;
    logic                   r_par,      w_par_nxt;
    logic                   r_tx,       w_tx_nxt;
    logic                   r_done,     w_done_nxt;
    logic                   w_bit_end;

    assign w_bit_end = tick && (r_tick_cnt == c_TICK_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_stop_nxt  = r_stop_cnt;
        w_shreg_nxt = r_shreg;
        w_par_nxt   = r_par;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                // Any tick arriving in the acceptance cycle is deliberately dropped.
                if (tx_valid) begin
                    w_state_nxt = START;
                    w_shreg_nxt = tx_data;
                    w_tick_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_stop_nxt  = '0;
                    w_par_nxt   = (PARITY == PAR_ODD) ? ~(^tx_data) : (^tx_data);
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_tick_nxt  = '0;
                end else if (tick) begin
                    w_tick_nxt = r_tick_cnt + 4'd1;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_tick_nxt  = '0;
                    w_shreg_nxt = {1'b0, r_shreg[DATA_BITS-1:1]};
                    if (r_bit_cnt == c_BIT_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end else if (tick) begin
                    w_tick_nxt = r_tick_cnt + 4'd1;
                end
            end
            uart_pkg::PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                    w_tick_nxt  = '0;
                end else if (tick) begin
                    w_tick_nxt = r_tick_cnt + 4'd1;
                end
            end
            STOP: begin
                // A dedicated 5-bit counter spans both stop bits in one count.
                if (tick) begin
                    if (r_stop_cnt == c_STOP_LAST) begin
                        w_state_nxt = IDLE;
                        w_stop_nxt  = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_stop_nxt = r_stop_cnt + 5'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Line level is derived from the next state so tx itself can be a flop.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            START:            w_tx_nxt = 1'b0;
            DATA:             w_tx_nxt = w_shreg_nxt[0];
            uart_pkg::PARITY: w_tx_nxt = w_par_nxt;
            default:          w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_shreg    <= '0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_stop_cnt <= w_stop_nxt;
            r_shreg    <= w_shreg_nxt;
            r_par      <= w_par_nxt;
            r_tx       <= w_tx_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign tx       = r_tx;
    assign tx_done  = r_done;
    assign tx_ready = (r_state == IDLE);
    assign tx_busy  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_ctrl
// Description : Self-checking bench for uart_tx_ctrl with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       tick     = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic       r0, r1, r2, t0, t1, t2, b0, b1, b2, d0, d1, d2;

    int checks   = 0;
    int failures = 0;
    int sel      = 0;
    int done_cnt [3];
    logic exp_bits [$];

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_none (
        .clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data), .tx_valid(v0),
        .tx_ready(r0), .tx(t0), .tx_busy(b0), .tx_done(d0));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_odd (
        .clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data), .tx_valid(v1),
        .tx_ready(r1), .tx(t1), .tx_busy(b1), .tx_done(d1));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_even (
        .clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data), .tx_valid(v2),
        .tx_ready(r2), .tx(t2), .tx_busy(b2), .tx_done(d2));

    initial begin
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        done_cnt[2] = 0;
    end

    always @(posedge clk) begin
        if (d0) done_cnt[0] = done_cnt[0] + 1;
        if (d1) done_cnt[1] = done_cnt[1] + 1;
        if (d2) done_cnt[2] = done_cnt[2] + 1;
    end

    function automatic logic pick(input logic a0, input logic a1, input logic a2);
        return (sel == 0) ? a0 : ((sel == 1) ? a1 : a2);
    endfunction

    task automatic set_valid(input logic v);
        case (sel)
            0:       v0 = v;
            1:       v1 = v;
            default: v2 = v;
        endcase
    endtask

    // Frame model: start, 8 data bits LSB first, optional parity, one stop bit.
    task automatic build_frame(input logic [7:0] d, input int par);
        int ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par == 1) exp_bits.push_back((ones % 2) == 0);
        if (par == 2) exp_bits.push_back((ones % 2) == 1);
        exp_bits.push_back(1'b1);
    endtask

    // Entered and left at a falling edge; instance s uses parity mode s.
    task automatic run_frame(input int s, input logic [7:0] d, input int period,
                             input bit tick_acc, input bit hold, input int stall_at);
        int n, cyc, total, stall_left;
        bit stalled, t;
        sel = s;
        build_frame(d, s);
        total = exp_bits.size() * 16;
        checks++;
        if (pick(r0, r1, r2) !== 1'b1) begin
            failures++;
            $display("FAIL ready_before_accept got=%b exp=1", pick(r0, r1, r2));
        end
        tx_data = d;
        set_valid(1'b1);
        tick = tick_acc;
        @(negedge clk);
        if (!hold) set_valid(1'b0);
        tick = 1'b0;
        checks++;
        if (pick(b0, b1, b2) !== 1'b1 || pick(r0, r1, r2) !== 1'b0) begin
            failures++;
            $display("FAIL accept_handshake busy=%b ready=%b exp busy=1 ready=0",
                     pick(b0, b1, b2), pick(r0, r1, r2));
        end
        n = 0;
        cyc = $urandom_range(0, period - 1);
        stall_left = 0;
        stalled = 1'b0;
        while (n < total) begin
            checks++;
            if (pick(t0, t1, t2) !== exp_bits[n / 16]) begin
                failures++;
                $display("FAIL tx_bit data=%h tick=%0d got=%b exp=%b",
                         d, n, pick(t0, t1, t2), exp_bits[n / 16]);
            end
            checks++;
            if (pick(d0, d1, d2) !== 1'b0 || pick(r0, r1, r2) !== 1'b0) begin
                failures++;
                $display("FAIL in_frame_flags tick=%0d done=%b ready=%b exp 0 0",
                         n, pick(d0, d1, d2), pick(r0, r1, r2));
            end
            if (stall_at > 0 && n == stall_at && !stalled) begin
                stalled = 1'b1;
                stall_left = 100;
            end
            t = 1'b0;
            if (stall_left > 0) begin
                stall_left--;
            end else begin
                cyc++;
                t = (cyc % period) == 0;
            end
            tick = t;
            if (t) n++;
            @(negedge clk);
        end
        tick = 1'b0;
        checks++;
        if (pick(d0, d1, d2) !== 1'b1 || pick(r0, r1, r2) !== 1'b1 ||
            pick(t0, t1, t2) !== 1'b1 || pick(b0, b1, b2) !== 1'b0) begin
            failures++;
            $display("FAIL frame_end done=%b ready=%b tx=%b busy=%b exp 1 1 1 0",
                     pick(d0, d1, d2), pick(r0, r1, r2), pick(t0, t1, t2), pick(b0, b1, b2));
        end
    endtask

    task automatic idle_check(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            tick = (i % 2) == 0;
            @(negedge clk);
            checks++;
            if (t0 !== 1'b1 || r0 !== 1'b1 || b0 !== 1'b0 || d0 !== 1'b0 ||
                t2 !== 1'b1 || r2 !== 1'b1 || b2 !== 1'b0 || d2 !== 1'b0) begin
                failures++;
                $display("FAIL %s tx=%b ready=%b busy=%b done=%b exp 1 1 0 0",
                         tag, t0, r0, b0, d0);
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_check(4, "reset_held");
        rst = 1'b0;
        idle_check(40, "reset_released");
    endtask

    task automatic test_single_frame();
        run_frame(0, 8'hA5, 4, 1'b0, 1'b0, 0);
        idle_check(3, "after_single");
    endtask

    task automatic test_back_to_back();
        int base = done_cnt[0];
        run_frame(0, 8'h00, 3, 1'b0, 1'b1, 0);
        run_frame(0, 8'hFF, 3, 1'b0, 1'b1, 0);
        set_valid(1'b0);
        @(negedge clk);
        checks++;
        if (done_cnt[0] - base !== 2) begin
            failures++;
            $display("FAIL b2b_done_pulses got=%0d exp=2", done_cnt[0] - base);
        end
        idle_check(3, "after_b2b");
    endtask

    task automatic test_parity();
        run_frame(2, 8'h07, 2, 1'b0, 1'b0, 0);
        idle_check(2, "after_even");
        run_frame(1, 8'h07, 2, 1'b0, 1'b0, 0);
        idle_check(2, "after_odd");
    endtask

    task automatic test_reset_mid_frame();
        int base, n, cyc;
        sel = 0;
        base = done_cnt[0];
        tx_data = 8'h3C;
        set_valid(1'b1);
        @(negedge clk);
        set_valid(1'b0);
        n = 0;
        cyc = 0;
        while (n < 16 * 4 + 8) begin
            cyc++;
            tick = (cyc % 2) == 0;
            if (tick) n++;
            @(negedge clk);
        end
        tick = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (t0 !== 1'b1 || r0 !== 1'b1 || b0 !== 1'b0 || d0 !== 1'b0) begin
            failures++;
            $display("FAIL async_reset tx=%b ready=%b busy=%b done=%b exp 1 1 0 0",
                     t0, r0, b0, d0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_check(20, "post_reset_idle");
        checks++;
        if (done_cnt[0] !== base) begin
            failures++;
            $display("FAIL reset_no_done got=%0d exp=%0d", done_cnt[0], base);
        end
        run_frame(0, 8'h3C, 2, 1'b0, 1'b0, 0);
        idle_check(2, "after_3c");
    endtask

    task automatic test_tick_edges();
        run_frame(0, 8'h5A, 4, 1'b1, 1'b0, 0);
        idle_check(2, "after_tick_accept");
        run_frame(0, 8'hC6, 3, 1'b0, 1'b0, 16 * 3 + 7);
        idle_check(2, "after_stall");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            run_frame(int'($urandom_range(0, 2)), 8'($urandom), int'($urandom_range(1, 5)),
                      1'($urandom_range(0, 1)), 1'b0, 0);
            idle_check(2, "after_random");
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_parity();
        test_reset_mid_frame();
        test_tick_edges();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
